vector_pair_fetcher: RTL and testbench

- Source-side counterpart of the result memory writer. On start, it reads operand vectors from mem1 and mem2 at the same addresses, address 0 upward.
- It streams each {mem1 word, mem2 word} pair to the dot-product datapath over a valid/ready interface.
- It sits between the two operand memories and the dot-product FIFOs, replacing ad-hoc read sequencing in the FSM.

---
 rtl/vector_pair_fetcher_pkg.sv | 26 ++
 rtl/vector_pair_fetcher_skid.sv | 49 ++++
 rtl/vector_pair_fetcher.sv | 133 +++++++++++++
 tb/tb_vector_pair_fetcher.sv | 315 +++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/vector_pair_fetcher_pkg.sv
// Shared types and constants for the operand pair fetch path.
package vector_pair_fetcher_pkg;

  // Fetch sequencer states.
  typedef enum logic [1:0] {
    StIdle,
    StFetch,
    StDrain,
    StDone
  } fetch_state_e;

  // Skid buffer depth; two entries cover one in-flight read plus one held pair.
  localparam int unsigned SKID_DEPTH = 2;
  localparam int unsigned SKID_PTR_W = 1;
  localparam int unsigned SKID_CNT_W = 2;

  // Default pair width, shared with the dot-product FIFO wrapper.
  localparam int unsigned DEFAULT_DATA_WIDTH = 32;
  localparam int unsigned PAIR_WIDTH         = 2 * DEFAULT_DATA_WIDTH;

  // Width of one {a, b} pair for a given word width.
  function automatic int unsigned pair_width(input int unsigned data_width);
    return 2 * data_width;
  endfunction

endpackage

// File: rtl/vector_pair_fetcher_skid.sv
// Two-entry FIFO of {a, b} pairs; push and pop may occur in the same cycle.
module pair_skid_buffer
  import vector_pair_fetcher_pkg::*;
#(
  parameter int unsigned WIDTH = PAIR_WIDTH
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  push,
  input  logic [WIDTH-1:0]      push_data,
  input  logic                  pop,
  output logic [SKID_CNT_W-1:0] occupancy,
  output logic [WIDTH-1:0]      head
);

  logic [WIDTH-1:0]      mem_q [SKID_DEPTH];
  logic [SKID_PTR_W-1:0] wr_ptr_q;
  logic [SKID_PTR_W-1:0] rd_ptr_q;
  logic [SKID_CNT_W-1:0] count_q;

  // Storage, pointers and occupancy; callers never push when full or pop when empty.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int i = 0; i < int'(SKID_DEPTH); i++) begin
        mem_q[i] <= '0;
      end
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      if (push) begin
        mem_q[wr_ptr_q] <= push_data;
        wr_ptr_q        <= wr_ptr_q + SKID_PTR_W'(1);
      end
      if (pop) begin
        rd_ptr_q <= rd_ptr_q + SKID_PTR_W'(1);
      end
      case ({push, pop})
        2'b10:   count_q <= count_q + SKID_CNT_W'(1);
        2'b01:   count_q <= count_q - SKID_CNT_W'(1);
        default: count_q <= count_q;
      endcase
    end
  end

  assign occupancy = count_q;
  assign head      = mem_q[rd_ptr_q];

endmodule

// File: rtl/vector_pair_fetcher.sv
// Reads operand words from mem1/mem2 at matching addresses from 0 upward and
// streams {mem1, mem2} pairs downstream over valid/ready.
module vector_pair_fetcher
  import vector_pair_fetcher_pkg::*;
#(
  parameter int unsigned DATA_WIDTH = 32,
  parameter int unsigned ADDR_WIDTH = 5,
  parameter int unsigned MEM_SIZE   = 32
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  start,
  input  logic [ADDR_WIDTH:0]   vec_count,
  output logic                  mem1_read_en,
  output logic [ADDR_WIDTH-1:0] mem1_read_address,
  input  logic [DATA_WIDTH-1:0] mem1_data_out,
  output logic                  mem2_read_en,
  output logic [ADDR_WIDTH-1:0] mem2_read_address,
  input  logic [DATA_WIDTH-1:0] mem2_data_out,
  output logic                  out_valid,
  input  logic                  out_ready,
  output logic [DATA_WIDTH-1:0] out_a,
  output logic [DATA_WIDTH-1:0] out_b,
  output logic                  fetch_ready,
  output logic                  busy,
  output logic                  done
);

  localparam int unsigned CntW  = ADDR_WIDTH + 1;
  localparam int unsigned PairW = pair_width(DATA_WIDTH);
  localparam logic [CntW-1:0] MemSizeCnt = CntW'(MEM_SIZE);

  fetch_state_e state_q, state_d;
  logic [CntW-1:0] eff_count_q, eff_count_d;
  logic [CntW-1:0] issue_cnt_q, issue_cnt_d;
  logic [CntW-1:0] accept_cnt_q, accept_cnt_d;
  logic [CntW-1:0] clamped_count;
  logic            inflight_q;
  logic            issue;
  logic            pop;
  logic [2:0]      projected;
  logic [SKID_CNT_W-1:0] occupancy;
  logic [PairW-1:0]      head;

  assign clamped_count = (vec_count > MemSizeCnt) ? MemSizeCnt : vec_count;
  assign out_valid     = (occupancy != '0);
  assign pop           = out_valid & out_ready;
  // Buffer fill once the pending read lands and this cycle's pop leaves.
  assign projected     = 3'(occupancy) + 3'(inflight_q) - 3'(pop);

  // Sequencer next state, counters and read issue.
  always_comb begin
    state_d      = state_q;
    eff_count_d  = eff_count_q;
    accept_cnt_d = pop ? accept_cnt_q + CntW'(1) : accept_cnt_q;
    issue        = 1'b0;
    fetch_ready  = 1'b0;
    busy         = 1'b0;
    done         = 1'b0;
    unique case (state_q)
      StIdle: begin
        fetch_ready = 1'b1;
        if (start) begin
          eff_count_d = clamped_count;
          state_d     = (clamped_count == '0) ? StDone : StFetch;
        end
      end
      StFetch: begin
        busy = 1'b1;
        if (issue_cnt_q == eff_count_q) begin
          state_d = StDrain;
        end else if (projected < 3'(SKID_DEPTH)) begin
          issue = 1'b1;
        end
      end
      StDrain: begin
        busy = 1'b1;
        // Finish as soon as the last pair is accepted, not a cycle later.
        if ((accept_cnt_d == eff_count_q) && (projected == '0)) begin
          state_d = StDone;
        end
      end
      StDone: begin
        done    = 1'b1;
        state_d = StIdle;
      end
      default: state_d = StIdle;
    endcase
    issue_cnt_d = issue ? issue_cnt_q + CntW'(1) : issue_cnt_q;
    if ((state_q == StIdle) && start) begin
      issue_cnt_d  = '0;
      accept_cnt_d = '0;
    end
  end

  // State and counter registers; reset drops any read still in flight.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q      <= StIdle;
      eff_count_q  <= '0;
      issue_cnt_q  <= '0;
      accept_cnt_q <= '0;
      inflight_q   <= 1'b0;
    end else begin
      state_q      <= state_d;
      eff_count_q  <= eff_count_d;
      issue_cnt_q  <= issue_cnt_d;
      accept_cnt_q <= accept_cnt_d;
      inflight_q   <= issue;
    end
  end

  assign mem1_read_en      = issue;
  assign mem2_read_en      = issue;
  assign mem1_read_address = issue ? issue_cnt_q[ADDR_WIDTH-1:0] : '0;
  assign mem2_read_address = mem1_read_address;

  pair_skid_buffer #(
    .WIDTH(PairW)
  ) u_skid (
    .clk      (clk),
    .rst      (rst),
    .push     (inflight_q),
    .push_data({mem1_data_out, mem2_data_out}),
    .pop      (pop),
    .occupancy(occupancy),
    .head     (head)
  );

  assign out_a = head[PairW-1 -: DATA_WIDTH];
  assign out_b = head[DATA_WIDTH-1:0];

endmodule

// File: tb/tb_vector_pair_fetcher.sv
// Self-checking bench for vector_pair_fetcher with registered-read memory models.
module tb_vector_pair_fetcher;

  logic        clk = 1'b0;
  logic        rst;
  logic        start;
  logic [5:0]  vec_count;
  logic        mem1_read_en, mem2_read_en;
  logic [4:0]  mem1_read_address, mem2_read_address;
  logic [31:0] mem1_data_out, mem2_data_out;
  logic        out_valid, out_ready;
  logic [31:0] out_a, out_b;
  logic        fetch_ready, busy, done;

  always #5 clk = ~clk;

  vector_pair_fetcher #(
    .DATA_WIDTH(32),
    .ADDR_WIDTH(5),
    .MEM_SIZE  (32)
  ) dut (
    .clk              (clk),
    .rst              (rst),
    .start            (start),
    .vec_count        (vec_count),
    .mem1_read_en     (mem1_read_en),
    .mem1_read_address(mem1_read_address),
    .mem1_data_out    (mem1_data_out),
    .mem2_read_en     (mem2_read_en),
    .mem2_read_address(mem2_read_address),
    .mem2_data_out    (mem2_data_out),
    .out_valid        (out_valid),
    .out_ready        (out_ready),
    .out_a            (out_a),
    .out_b            (out_b),
    .fetch_ready      (fetch_ready),
    .busy             (busy),
    .done             (done)
  );

  // Operand memories: data appears one cycle after the read strobe.
  logic [31:0] mem1_arr [32];
  logic [31:0] mem2_arr [32];
  always @(posedge clk) begin
    if (mem1_read_en) mem1_data_out <= mem1_arr[mem1_read_address];
    if (mem2_read_en) mem2_data_out <= mem2_arr[mem2_read_address];
  end

  int n_checks = 0;
  int n_errors = 0;
  int cyc = 0;
  int start_cyc;

  always @(posedge clk) cyc++;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h, expected %0h", name, act, exp);
    end
  endtask

  // Monitor: records traffic and checks handshake invariants every cycle.
  int          rd_addr_q [$];
  int          rd_cyc_q [$];
  logic [31:0] pa_q [$];
  logic [31:0] pb_q [$];
  int          pop_cyc_q [$];
  int          done_cyc_q [$];
  int          first_valid_cyc;
  logic        prev_stall;
  logic [31:0] prev_a, prev_b;
  logic        mon_pop;

  always @(negedge clk) begin
    if (rst) begin
      prev_stall <= 1'b0;
    end else begin
      mon_pop = out_valid && out_ready;
      if (mem1_read_en || mem2_read_en) begin
        check("mem2_mirror", {mem2_read_en, 3'b0, mem2_read_address},
              {mem1_read_en, 3'b0, mem1_read_address});
      end
      if (mem1_read_en) begin
        // Issued reads not yet accepted (including this one) must fit the buffer.
        check("issue_bound",
              64'((rd_addr_q.size() + 1 - pa_q.size() - int'(mon_pop)) <= 2), 64'd1);
        rd_addr_q.push_back(int'(mem1_read_address));
        rd_cyc_q.push_back(cyc);
      end
      if (prev_stall) begin
        check("stall_hold", {out_valid, out_a, out_b}, {1'b1, prev_a, prev_b});
      end
      if (out_valid && first_valid_cyc < 0) first_valid_cyc = cyc;
      if (mon_pop) begin
        pa_q.push_back(out_a);
        pb_q.push_back(out_b);
        pop_cyc_q.push_back(cyc);
      end
      if (done) done_cyc_q.push_back(cyc);
      prev_stall <= out_valid && !out_ready;
      prev_a     <= out_a;
      prev_b     <= out_b;
    end
  end

  task automatic clear_mon();
    rd_addr_q.delete();
    rd_cyc_q.delete();
    pa_q.delete();
    pb_q.delete();
    pop_cyc_q.delete();
    done_cyc_q.delete();
    first_valid_cyc = -1;
  endtask

  function automatic logic ready_for(input int mode, input int k);
    case (mode)
      0:       return 1'b1;
      1:       return (k % 3 == 0);
      2:       return 1'($urandom_range(0, 1));
      default: return 1'b0;
    endcase
  endfunction

  task automatic fill_pattern();
    for (int i = 0; i < 32; i++) begin
      mem1_arr[i] = {8'(1 + i), 8'(2 + i), 8'(3 + i), 8'(4 + i)};
      mem2_arr[i] = mem1_arr[i];
    end
  endtask

  task automatic fill_random();
    for (int i = 0; i < 32; i++) begin
      mem1_arr[i] = $urandom;
      mem2_arr[i] = $urandom;
    end
  endtask

  // Called at posedge+1; pulses start for one cycle.
  task automatic kick(input int n, input logic rdy);
    clear_mon();
    start     = 1'b1;
    vec_count = 6'(n);
    out_ready = rdy;
    start_cyc = cyc;
    @(posedge clk); #1;
    start = 1'b0;
  endtask

  task automatic wait_done(input int mode, input int budget, input string name);
    bit seen = 0;
    for (int k = 1; k < budget && !seen; k++) begin
      out_ready = ready_for(mode, k);
      @(posedge clk); #1;
      if (done_cyc_q.size() > 0) seen = 1;
    end
    if (!seen) check({name, "_timeout"}, 64'd0, 64'd1);
    out_ready = 1'b1;
    repeat (3) begin
      @(posedge clk); #1;
    end
  endtask

  // Reference: a run delivers min(n, 32) pairs, {mem1[i], mem2[i]} for i in order.
  task automatic compare_run(input int exp_pairs, input string name);
    int bad_data = 0;
    int bad_addr = 0;
    check({name, "_pairs"}, 64'(pa_q.size()), 64'(exp_pairs));
    check({name, "_reads"}, 64'(rd_addr_q.size()), 64'(exp_pairs));
    for (int i = 0; i < pa_q.size() && i < exp_pairs; i++) begin
      if (pa_q[i] !== mem1_arr[i] || pb_q[i] !== mem2_arr[i]) bad_data++;
    end
    for (int i = 0; i < rd_addr_q.size(); i++) begin
      if (rd_addr_q[i] != i) bad_addr++;
    end
    check({name, "_data"}, 64'(bad_data), 64'd0);
    check({name, "_addr"}, 64'(bad_addr), 64'd0);
    check({name, "_done_count"}, 64'(done_cyc_q.size()), 64'd1);
  endtask

  typedef struct {
    int    vec_count;
    int    ready_mode;
    int    exp_pairs;
    string name;
  } vec_t;

  vec_t        table_v [6];
  logic [31:0] basic_exp [4];

  initial begin
    rst       = 1'b1;
    start     = 1'b0;
    vec_count = '0;
    out_ready = 1'b0;
    first_valid_cyc = -1;
    basic_exp[0] = 32'h01020304;
    basic_exp[1] = 32'h02030405;
    basic_exp[2] = 32'h03040506;
    basic_exp[3] = 32'h04050607;
    table_v[0] = '{6, 1, 6, "backpressure"};
    table_v[1] = '{40, 0, 32, "saturate"};
    table_v[2] = '{1, 0, 1, "single"};
    table_v[3] = '{32, 2, 32, "full_rand"};
    table_v[4] = '{33, 1, 32, "over_by_one"};
    table_v[5] = '{2, 2, 2, "two"};

    repeat (3) @(posedge clk);
    #1;
    check("rst_outputs",
          {fetch_ready, busy, done, out_valid, mem1_read_en, mem2_read_en},
          6'b100000);
    check("rst_addr", {mem1_read_address, mem2_read_address}, 10'd0);
    check("rst_data", {out_a, out_b}, 64'd0);
    rst = 1'b0;
    @(posedge clk); #1;

    // Basic run with the incrementing pattern and fixed latency expectations.
    fill_pattern();
    kick(4, 1'b1);
    wait_done(0, 100, "basic");
    compare_run(4, "basic");
    for (int i = 0; i < 4 && i < pa_q.size(); i++) begin
      check("basic_word", {pa_q[i], pb_q[i]}, {basic_exp[i], basic_exp[i]});
    end
    for (int i = 0; i < 4 && i < rd_cyc_q.size(); i++) begin
      check("basic_read_cycle", 64'(rd_cyc_q[i] - start_cyc), 64'(1 + i));
    end
    // Two edges after the edge that samples start.
    check("basic_valid_latency", 64'(first_valid_cyc - start_cyc), 64'd3);
    if (pop_cyc_q.size() > 0 && done_cyc_q.size() > 0) begin
      check("basic_done_after_pop", 64'(done_cyc_q[0] - pop_cyc_q[pop_cyc_q.size() - 1]), 64'd1);
    end

    // Table of runs over the same memory pattern.
    for (int t = 0; t < 6; t++) begin
      kick(table_v[t].vec_count, ready_for(table_v[t].ready_mode, 0));
      wait_done(table_v[t].ready_mode, 400, table_v[t].name);
      compare_run(table_v[t].exp_pairs, table_v[t].name);
    end

    // Zero-length run: a lone done pulse and no reads.
    kick(0, 1'b1);
    wait_done(0, 20, "zero");
    check("zero_reads", 64'(rd_addr_q.size()), 64'd0);
    check("zero_done_count", 64'(done_cyc_q.size()), 64'd1);
    if (done_cyc_q.size() > 0) begin
      check("zero_done_soon", 64'((done_cyc_q[0] - start_cyc) inside {[1:2]}), 64'd1);
    end

    // Full depth with the sink stalled: only two reads until it releases.
    fill_random();
    kick(32, 1'b0);
    repeat (10) begin
      @(posedge clk); #1;
    end
    check("stall_reads", 64'(rd_addr_q.size()), 64'd2);
    check("stall_busy", {busy, out_valid}, 2'b11);
    wait_done(0, 200, "stall_release");
    compare_run(32, "stall_release");

    // Reset after the third pop of a ten-pair run.
    begin
      bit got3 = 0;
      kick(10, 1'b1);
      for (int k = 0; k < 50 && !got3; k++) begin
        @(posedge clk); #1;
        if (pa_q.size() >= 3) got3 = 1;
      end
      check("midrst_reached", 64'(got3), 64'd1);
      rst = 1'b1;
      #1;
      check("midrst_outputs",
            {fetch_ready, busy, done, out_valid, mem1_read_en, mem2_read_en},
            6'b100000);
      check("midrst_data", {out_a, out_b, mem1_read_address}, 69'd0);
      @(posedge clk); #1;
      rst = 1'b0;
      clear_mon();
      repeat (6) begin
        @(posedge clk); #1;
      end
      check("midrst_no_valid", 64'(first_valid_cyc < 0), 64'd1);
      check("midrst_no_reads", 64'(rd_addr_q.size()), 64'd0);
      kick(2, 1'b1);
      wait_done(0, 50, "after_rst");
      compare_run(2, "after_rst");
    end

    // Start pulse during FETCH is ignored.
    kick(5, 1'b1);
    start     = 1'b1;
    vec_count = 6'd3;
    @(posedge clk); #1;
    start = 1'b0;
    wait_done(0, 100, "busy_start");
    compare_run(5, "busy_start");

    // Randomized runs against the reference model.
    for (int r = 0; r < 12; r++) begin
      int n;
      fill_random();
      n = int'($urandom_range(0, 63));
      kick(n, ready_for(2, 0));
      wait_done(2, 600, "random");
      compare_run((n > 32) ? 32 : n, "random");
    end

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
